led_water_ctrl: RTL and testbench

- Sequencer for the 8-bit running-light ("LED water") display.
- Divides `clk` down to a step tick and advances an 8-bit LED pattern in one of four selectable modes.
- Supports enable, pause (`stop`) and live mode/speed changes.
- Drives the board LED bus directly and gives step and wrap status to upstream control logic.

---
 rtl/led_water_ctrl.sv | 178 +++++++++++++++++
 tb/tb_led_water_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/led_water_ctrl.sv
// Running-light sequencer: divides clk down to a step tick and walks an
// 8-bit LED pattern in rotate-left, rotate-right, ping-pong or blink mode.
module led_water_ctrl #(
  parameter int DIV   = 25,
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       stop,
  input  logic [1:0] mode,
  input  logic [1:0] speed,
  output logic [7:0] led,
  output logic       tick,
  output logic       wrap,
  output logic       running
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [1:0] M_ROL   = 2'b00;
  localparam logic [1:0] M_ROR   = 2'b01;
  localparam logic [1:0] M_PING  = 2'b10;
  localparam logic [1:0] M_BLINK = 2'b11;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_m1;
  logic [7:0]       led_q, led_d;
  logic             dir_r_q, dir_r_d;   // ping-pong direction, 1 = moving right
  logic [1:0]       mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             running_q;
  logic [7:0]       nxt_led;
  logic             nxt_dir_r;

  function automatic logic [7:0] start_pattern(input logic [1:0] m);
    case (m)
      M_ROL:   start_pattern = 8'h01;
      M_ROR:   start_pattern = 8'h80;
      M_PING:  start_pattern = 8'h01;
      default: start_pattern = 8'hFF;
    endcase
  endfunction

  // Ping-pong bounces off the end LEDs instead of rotating through them.
  function automatic logic [7:0] next_pattern(input logic [1:0] m,
                                              input logic [7:0] cur,
                                              input logic       dir_r);
    case (m)
      M_ROL:  next_pattern = {cur[6:0], cur[7]};
      M_ROR:  next_pattern = {cur[0], cur[7:1]};
      M_PING: begin
        if (!dir_r) next_pattern = (cur == 8'h80) ? 8'h40 : {cur[6:0], 1'b0};
        else        next_pattern = (cur == 8'h01) ? 8'h02 : {1'b0, cur[7:1]};
      end
      default: next_pattern = ~cur;
    endcase
  endfunction

  function automatic logic next_dir(input logic [1:0] m,
                                    input logic [7:0] cur,
                                    input logic       dir_r);
    next_dir = dir_r;
    if (m == M_PING) begin
      if (!dir_r && cur == 8'h80) next_dir = 1'b1;
      if (dir_r && cur == 8'h01)  next_dir = 1'b0;
    end
  endfunction

  // A full cycle ends when the freshly stepped pattern is back at its home value.
  function automatic logic wrap_hit(input logic [1:0] m, input logic [7:0] nl);
    case (m)
      M_ROL:   wrap_hit = (nl == 8'h01);
      M_ROR:   wrap_hit = (nl == 8'h80);
      M_PING:  wrap_hit = (nl == 8'h01);
      default: wrap_hit = (nl == 8'hFF);
    endcase
  endfunction

  // Step period minus one; compare is >= so a speed-up never strands the count.
  always_comb begin
    n_m1 = (CNT_W'(DIV) << speed) - CNT_W'(1);
  end

  // Candidate next pattern and direction for the current mode.
  always_comb begin
    nxt_led   = next_pattern(mode_q, led_q, dir_r_q);
    nxt_dir_r = next_dir(mode_q, led_q, dir_r_q);
  end

  // Next-state logic: en=0 beats mode change, which beats stop, which beats the step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    dir_r_d = dir_r_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        led_d = 8'h00;
        cnt_d = '0;
        if (en) begin
          state_d = stop ? PAUSE : RUN;
          led_d   = start_pattern(mode);
          mode_d  = mode;
          dir_r_d = 1'b0;
        end
      end
      RUN, PAUSE: begin
        if (!en) begin
          state_d = IDLE;
          led_d   = 8'h00;
          cnt_d   = '0;
        end else if (mode != mode_q) begin
          led_d   = start_pattern(mode);
          cnt_d   = '0;
          dir_r_d = 1'b0;
          mode_d  = mode;
        end else if (stop) begin
          state_d = PAUSE;
        end else begin
          state_d = RUN;
          if (cnt_q >= n_m1) begin
            cnt_d   = '0;
            led_d   = nxt_led;
            dir_r_d = nxt_dir_r;
            tick_d  = 1'b1;
            wrap_d  = wrap_hit(mode_q, nxt_led);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        led_d   = 8'h00;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; mode_q tracks the mode input while in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      led_q     <= 8'h00;
      dir_r_q   <= 1'b0;
      mode_q    <= mode;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      led_q     <= led_d;
      dir_r_q   <= dir_r_d;
      mode_q    <= mode_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
      running_q <= (state_d == RUN);
    end
  end

  assign led     = led_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;
  assign running = running_q;

endmodule

// File: tb/tb_led_water_ctrl.sv
// Directed bench for led_water_ctrl: DIV=4 instance for most scenarios and a
// DIV=2 instance sharing the same inputs for the ping-pong sequence.
module tb_led_water_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       stop;
  logic [1:0] mode;
  logic [1:0] speed;
  logic [7:0] led;
  logic       tick;
  logic       wrap;
  logic       running;
  logic [7:0] led2;
  logic       tick2;
  logic       wrap2;
  logic       running2;

  int passes;
  int fails;
  int total;

  logic [7:0] exp_led;
  logic [7:0] pp_seq [14];

  led_water_ctrl #(.DIV(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .stop(stop), .mode(mode), .speed(speed),
    .led(led), .tick(tick), .wrap(wrap), .running(running)
  );

  led_water_ctrl #(.DIV(2), .CNT_W(32)) dut2 (
    .clk(clk), .rst(rst), .en(en), .stop(stop), .mode(mode), .speed(speed),
    .led(led2), .tick(tick2), .wrap(wrap2), .running(running2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    total++;
    assert (obs === want) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  initial begin
    passes = 0;
    fails  = 0;
    total  = 0;
    pp_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
               8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    // Reset
    rst = 1'b1; en = 1'b0; stop = 1'b0; mode = 2'b00; speed = 2'b00;
    cyc(2);
    chk("rst_led", led, 8'h00);
    chk("rst_tick", {7'd0, tick}, 8'd0);
    chk("rst_wrap", {7'd0, wrap}, 8'd0);
    chk("rst_running", {7'd0, running}, 8'd0);
    chk("rst_led2", led2, 8'h00);
    rst = 1'b0;
    cyc(1);
    chk("idle_led", led, 8'h00);

    // Basic rotate-left, DIV=4
    en = 1'b1;
    cyc(1);
    chk("rol_start", led, 8'h01);
    chk("rol_running", {7'd0, running}, 8'd1);
    chk("rol_start_tick", {7'd0, tick}, 8'd0);
    exp_led = 8'h01;
    for (int k = 1; k <= 11; k++) begin
      cyc(3);
      chk("rol_gap_tick", {7'd0, tick}, 8'd0);
      cyc(1);
      exp_led = {exp_led[6:0], exp_led[7]};
      chk("rol_led", led, exp_led);
      chk("rol_tick", {7'd0, tick}, 8'd1);
      chk("rol_wrap", {7'd0, wrap}, (k == 8) ? 8'd1 : 8'd0);
    end
    chk("rol_at_08", led, 8'h08);

    // Mode change to blink at led=08
    mode = 2'b11;
    cyc(1);
    chk("mchg_led", led, 8'hFF);
    chk("mchg_tick", {7'd0, tick}, 8'd0);
    chk("mchg_wrap", {7'd0, wrap}, 8'd0);
    cyc(3);
    chk("blink_gap", {7'd0, tick}, 8'd0);
    cyc(1);
    chk("blink_led0", led, 8'h00);
    chk("blink_tick0", {7'd0, tick}, 8'd1);
    chk("blink_wrap0", {7'd0, wrap}, 8'd0);
    cyc(4);
    chk("blink_led1", led, 8'hFF);
    chk("blink_wrap1", {7'd0, wrap}, 8'd1);

    // Speed 2: N = 16
    speed = 2'd2;
    cyc(15);
    chk("spd2_gap_tick", {7'd0, tick}, 8'd0);
    chk("spd2_gap_led", led, 8'hFF);
    cyc(1);
    chk("spd2_led0", led, 8'h00);
    chk("spd2_tick0", {7'd0, tick}, 8'd1);
    cyc(15);
    chk("spd2_gap2", {7'd0, tick}, 8'd0);
    cyc(1);
    chk("spd2_led1", led, 8'hFF);
    chk("spd2_wrap1", {7'd0, wrap}, 8'd1);

    // Speed 3 (N=32), drop to speed 0 at cnt=20
    speed = 2'd3;
    cyc(20);
    chk("spd3_no_tick", {7'd0, tick}, 8'd0);
    chk("spd3_led", led, 8'hFF);
    speed = 2'd0;
    cyc(1);
    chk("spddn_tick", {7'd0, tick}, 8'd1);
    chk("spddn_led", led, 8'h00);
    chk("spddn_wrap", {7'd0, wrap}, 8'd0);
    cyc(3);
    chk("spddn_gap", {7'd0, tick}, 8'd0);
    cyc(1);
    chk("spddn_led1", led, 8'hFF);
    chk("spddn_tick1", {7'd0, tick}, 8'd1);
    chk("spddn_wrap1", {7'd0, wrap}, 8'd1);

    // Disable, re-enable, reset mid-count
    en = 1'b0;
    cyc(1);
    chk("dis_led", led, 8'h00);
    chk("dis_running", {7'd0, running}, 8'd0);
    chk("dis_tick", {7'd0, tick}, 8'd0);
    mode = 2'b00;
    en = 1'b1;
    cyc(1);
    chk("reen_led", led, 8'h01);
    chk("reen_running", {7'd0, running}, 8'd1);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    chk("mrst_led", led, 8'h00);
    chk("mrst_running", {7'd0, running}, 8'd0);
    chk("mrst_tick", {7'd0, tick}, 8'd0);
    cyc(1);
    chk("mrst_hold_running", {7'd0, running}, 8'd0);
    chk("mrst_hold_led", led, 8'h00);
    rst = 1'b0;
    cyc(1);
    chk("postrst_led", led, 8'h01);
    chk("postrst_running", {7'd0, running}, 8'd1);

    // Pause in rotate-right at led=20
    mode = 2'b01;
    cyc(1);
    chk("ror_start", led, 8'h80);
    chk("ror_start_tick", {7'd0, tick}, 8'd0);
    cyc(3);
    cyc(1);
    chk("ror_led40", led, 8'h40);
    chk("ror_wrap40", {7'd0, wrap}, 8'd0);
    cyc(4);
    chk("ror_led20", led, 8'h20);
    chk("ror_tick20", {7'd0, tick}, 8'd1);
    cyc(1);
    stop = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk("pause_led", led, 8'h20);
      chk("pause_tick", {7'd0, tick}, 8'd0);
      chk("pause_running", {7'd0, running}, 8'd0);
    end
    stop = 1'b0;
    cyc(1);
    chk("resume_running", {7'd0, running}, 8'd1);
    chk("resume_tick0", {7'd0, tick}, 8'd0);
    cyc(1);
    chk("resume_tick1", {7'd0, tick}, 8'd0);
    cyc(1);
    chk("resume_led", led, 8'h10);
    chk("resume_tick", {7'd0, tick}, 8'd1);

    // Ping-pong on the DIV=2 instance
    rst = 1'b1; mode = 2'b10; en = 1'b1; stop = 1'b0; speed = 2'd0;
    cyc(2);
    chk("pp_rst_running", {7'd0, running2}, 8'd0);
    rst = 1'b0;
    cyc(1);
    chk("pp_start", led2, 8'h01);
    for (int k = 0; k < 14; k++) begin
      cyc(1);
      chk("pp_gap_tick", {7'd0, tick2}, 8'd0);
      cyc(1);
      chk("pp_led", led2, pp_seq[k]);
      chk("pp_tick", {7'd0, tick2}, 8'd1);
      chk("pp_wrap", {7'd0, wrap2}, (k == 13) ? 8'd1 : 8'd0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
